// File: rtl/packing_controller_pkg.sv
// Shared types and constants for the compressed-line packing controller.
// Contents: FSM state enum, chunk/length limits, length clamp helper.
// No logic of its own; imported by packing_controller.
package packing_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PACK  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int CHUNK_BITS   = 64;
  localparam int MAX_CODE_LEN = 34;
  localparam int FILL_MAX     = 131;
  localparam int LINE_BITS_W  = 10;

  // Wide enough for the largest fill (63 + 2 * MAX_CODE_LEN).
  localparam int FILL_W = $clog2(FILL_MAX + 1);

  // A code longer than the longest legal code is treated as the longest one.
  function automatic logic [FILL_W-1:0] clamp_len(input logic [FILL_W-1:0] len);
    if (len > FILL_W'(MAX_CODE_LEN)) begin
      return FILL_W'(MAX_CODE_LEN);
    end
    return len;
  endfunction

endpackage

// File: rtl/packing_controller.sv
// Purpose: steers a pair shifter that packs variable-length compressed words
//          into fixed CACHE_LINE-bit chunks, then flushes the partial tail.
// Latency: pair accepted the cycle it is offered (if room); chunk valid the
//          cycle after the fill reaches a full chunk.
// Backpressure: o_pair_ready drops while a full chunk waits; chunk outputs
//          hold steady until i_out_ready completes the handshake.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   begin a line (only honoured in IDLE)
//   i_pair_valid, i_len1/2    offered word pair and its compressed lengths
//   o_pair_ready, o_latch_en  pair accepted this cycle / capture datapath
//   o_word2_length            word1 shifter amount (clamped len2)
//   o_total_length            pair shifter fill offset before this pair
//   o_out_valid/_shift/_last  chunk available, its valid bits, final chunk
//   i_out_ready               downstream takes the chunk
//   o_done, o_line_bits       end-of-line pulse, total bits of the line
//   o_len_err                 sticky: an over-long length was seen this line
module packing_controller
  import packing_controller_pkg::*;
#(
  parameter int WORD2_LENGTH   = 6,
  parameter int TOTAL_LENGTH   = 7,
  parameter int OUT_SHIFT_BIT  = 7,
  parameter int CACHE_LINE     = 64,
  parameter int WORDS_PER_LINE = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_pair_valid,
  input  logic [WORD2_LENGTH-1:0]  i_len1,
  input  logic [WORD2_LENGTH-1:0]  i_len2,
  output logic                     o_pair_ready,
  output logic                     o_latch_en,
  output logic [WORD2_LENGTH-1:0]  o_word2_length,
  output logic [TOTAL_LENGTH-1:0]  o_total_length,
  output logic [OUT_SHIFT_BIT-1:0] o_out_shift,
  output logic                     o_out_valid,
  output logic                     o_out_last,
  input  logic                     i_out_ready,
  output logic                     o_done,
  output logic [LINE_BITS_W-1:0]   o_line_bits,
  output logic                     o_len_err
);

  localparam int PAIRS = WORDS_PER_LINE / 2;
  localparam int PC_W  = $clog2(PAIRS + 1);
  localparam logic [FILL_W-1:0] CHUNK_F = FILL_W'(CACHE_LINE);

  state_t state, state_nxt;

  logic [FILL_W-1:0]      fill;
  logic [PC_W-1:0]        pair_cnt;
  logic [LINE_BITS_W-1:0] line_bits;
  logic                   len_err;

  logic [FILL_W-1:0] len1_raw, len2_raw;
  logic [FILL_W-1:0] len1_c, len2_c, pair_bits;
  logic              len_over;
  logic              fill_full;
  logic              last_pair;
  logic              accept;
  logic              chunk_hs;
  logic              start_line;

  assign len1_raw  = FILL_W'(i_len1);
  assign len2_raw  = FILL_W'(i_len2);
  assign len1_c    = clamp_len(len1_raw);
  assign len2_c    = clamp_len(len2_raw);
  assign len_over  = (len1_c != len1_raw) || (len2_c != len2_raw);
  assign pair_bits = len1_c + len2_c;

  assign fill_full  = (fill >= CHUNK_F);
  assign last_pair  = (pair_cnt == PC_W'(PAIRS - 1));
  assign start_line = (state == ST_IDLE) && i_start;

  // A pair is only taken while the packing register has less than one chunk
  // buffered, so acceptance and chunk emission can never coincide and the
  // fill tops out at 63 + 68.
  assign accept   = (state == ST_PACK) && !fill_full && i_pair_valid;
  assign chunk_hs = o_out_valid && i_out_ready;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and chunk outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    o_pair_ready = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    o_out_shift  = '0;

    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_PACK;
        end
      end

      ST_PACK: begin
        o_pair_ready = !fill_full;
        if (fill_full) begin
          o_out_valid = 1'b1;
          o_out_shift = OUT_SHIFT_BIT'(CACHE_LINE);
        end
        if (accept && last_pair) begin
          state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (fill_full) begin
          o_out_valid = 1'b1;
          o_out_shift = OUT_SHIFT_BIT'(CACHE_LINE);
          // A line whose size is an exact multiple of a chunk ends here.
          o_out_last  = (fill == CHUNK_F);
          if (i_out_ready && (fill == CHUNK_F)) begin
            state_nxt = ST_DONE;
          end
        end else if (fill != '0) begin
          state_nxt = ST_FLUSH;
        end else begin
          state_nxt = ST_DONE;
        end
      end

      ST_FLUSH: begin
        o_out_valid = 1'b1;
        o_out_shift = OUT_SHIFT_BIT'(fill);
        o_out_last  = 1'b1;
        if (i_out_ready) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Fill, pair count, line size and error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill      <= '0;
      pair_cnt  <= '0;
      line_bits <= '0;
      len_err   <= 1'b0;
    end else if (start_line) begin
      fill      <= '0;
      pair_cnt  <= '0;
      line_bits <= '0;
      len_err   <= 1'b0;
    end else if (accept) begin
      fill      <= fill + pair_bits;
      line_bits <= line_bits + LINE_BITS_W'(pair_bits);
      pair_cnt  <= pair_cnt + PC_W'(1);
      if (len_over) begin
        len_err <= 1'b1;
      end
    end else if (chunk_hs) begin
      if (state == ST_FLUSH) begin
        fill <= '0;
      end else begin
        fill <= fill - CHUNK_F;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath steering: only meaningful on the accepting cycle, zero
  // otherwise so the shifters see quiet controls while idle or in reset.
  // ---------------------------------------------------------------------
  assign o_latch_en     = accept;
  assign o_word2_length = accept ? WORD2_LENGTH'(len2_c) : '0;
  assign o_total_length = accept ? TOTAL_LENGTH'(fill) : '0;

  assign o_done      = (state == ST_DONE);
  assign o_line_bits = line_bits;
  assign o_len_err   = len_err;

endmodule

// File: tb/tb_packing_controller.sv
// Bench for packing_controller: directed lines plus randomized lines with
// random pair gaps, random downstream stalls and ignored stray i_start /
// i_pair_valid, all checked against a line-level bit-accounting model.
module tb_packing_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pair_valid = 1'b0;
  logic [5:0] len1 = '0;
  logic [5:0] len2 = '0;
  logic       out_ready = 1'b1;

  logic       pair_ready, latch_en, out_valid, out_last, done, len_err;
  logic [5:0] word2_length;
  logic [6:0] total_length;
  logic [6:0] out_shift;
  logic [9:0] line_bits;

  packing_controller dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_pair_valid   (pair_valid),
    .i_len1         (len1),
    .i_len2         (len2),
    .o_pair_ready   (pair_ready),
    .o_latch_en     (latch_en),
    .o_word2_length (word2_length),
    .o_total_length (total_length),
    .o_out_shift    (out_shift),
    .o_out_valid    (out_valid),
    .o_out_last     (out_last),
    .i_out_ready    (out_ready),
    .o_done         (done),
    .o_line_bits    (line_bits),
    .o_len_err      (len_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int clampl(input int l);
    return (l > 34) ? 34 : l;
  endfunction

  // ---------------------------------------------------------------------
  // Line-level model: a line is just a running bit total. Every pair is
  // offered its slot at total % 64; chunks peel off 64 bits at a time and
  // the leftover goes out as a final short chunk.
  // ---------------------------------------------------------------------
  bit in_line = 0;
  int sum, pairs, emitted, held_bits = 0;
  bit exp_err;
  int prev_v = 0, prev_r = 0, prev_shift = 0, prev_last = 0;

  // Per-line record for hand-computed expectations.
  int rec_chunks, rec_last_shift, rec_last_flags, rec_done, rec_line_bits;
  int rec_err, rec_short_chunks;
  int rec_tl[8];

  always @(negedge clk) begin
    int  fill, l1, l2, exp_shift, exp_last, z;
    bit  acc, hs;
    if (!rst_n) begin
      z = int'(pair_ready) + int'(latch_en) + int'(word2_length) +
          int'(total_length) + int'(out_shift) + int'(out_valid) +
          int'(out_last) + int'(done) + int'(line_bits) + int'(len_err);
      check("reset_outputs_zero", z, 0);
      in_line   = 0;
      held_bits = 0;
      prev_v    = 0;
    end else begin
      acc = pair_valid && pair_ready;
      hs  = out_valid && out_ready;
      check("ready_valid_exclusive", int'(pair_ready && out_valid), 0);
      if (prev_v != 0 && prev_r == 0) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_shift_held", int'(out_shift), prev_shift);
        check("stall_last_held", int'(out_last), prev_last);
      end
      if (!in_line) begin
        check("idle_pair_ready", int'(pair_ready), 0);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_latch_en", int'(latch_en), 0);
        check("idle_done", int'(done), 0);
        check("line_bits_held", int'(line_bits), held_bits);
        if (start) begin
          in_line = 1; sum = 0; pairs = 0; emitted = 0; exp_err = 0;
          rec_chunks = 0; rec_last_shift = 0; rec_last_flags = 0;
          rec_done = 0; rec_line_bits = -1; rec_err = -1; rec_short_chunks = 0;
          for (int i = 0; i < 8; i++) rec_tl[i] = -1;
        end
      end else begin
        fill = sum - emitted;
        check("len_err", int'(len_err), int'(exp_err));
        check("latch_en", int'(latch_en), int'(acc));
        if (pairs < 8) begin
          check("pair_ready", int'(pair_ready), int'(fill < 64));
          check("chunk_valid_while_packing", int'(out_valid), int'(fill >= 64));
        end else begin
          check("ready_after_last_pair", int'(pair_ready), 0);
        end
        if (acc) begin
          l1 = clampl(int'(len1));
          l2 = clampl(int'(len2));
          check("total_length", int'(total_length), sum % 64);
          check("word2_length", int'(word2_length), l2);
          rec_tl[pairs] = int'(total_length);
          sum += l1 + l2;
          pairs++;
          if (len1 > 34 || len2 > 34) exp_err = 1;
        end
        if (out_valid) begin
          if (emitted + 64 <= sum) begin
            exp_shift = 64;
            exp_last  = int'(pairs == 8 && emitted + 64 == sum);
          end else begin
            exp_shift = sum - emitted;
            exp_last  = 1;
            check("short_chunk_after_last_pair", pairs, 8);
          end
          check("chunk_shift", int'(out_shift), exp_shift);
          check("chunk_last", int'(out_last), exp_last);
          if (hs) begin
            emitted += exp_shift;
            rec_chunks++;
            rec_last_shift = int'(out_shift);
            if (out_last) rec_last_flags++;
            if (out_shift != 64) rec_short_chunks++;
          end
        end
        if (done) begin
          check("done_all_pairs", pairs, 8);
          check("done_all_bits_emitted", emitted, sum);
          check("done_line_bits", int'(line_bits), sum);
          held_bits     = sum;
          in_line       = 0;
          rec_done++;
          rec_line_bits = int'(line_bits);
          rec_err       = int'(len_err);
        end
      end
      prev_v     = int'(out_valid);
      prev_r     = int'(out_ready);
      prev_shift = int'(out_shift);
      prev_last  = int'(out_last);
    end
  end

  // ---------------------------------------------------------------------
  // Downstream ready: 0 = always ready, 1 = random, 2 = five-cycle stalls
  // ---------------------------------------------------------------------
  int rdy_mode = 0;
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        1:       out_ready = 1'($urandom_range(1));
        2:       out_ready = ((cyc % 6) == 5);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one line. abort_at >= 0 pulses reset instead of offering that pair.
  task automatic run_line(input int lens[16], input int gap_pct,
                          input bit noisy, input int abort_at);
    bit got;
    if (noisy) begin
      pair_valid = 1'b1;
      len1 = 6'($urandom_range(63));
      len2 = 6'($urandom_range(63));
      tick();
      pair_valid = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 8; p++) begin
      if (p == abort_at) begin
        pair_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        pair_valid = 1'b0;
        tick();
      end
      pair_valid = 1'b1;
      len1 = 6'(lens[2*p]);
      len2 = 6'(lens[2*p+1]);
      got = 0;
      for (int w = 0; w < 300 && !got; w++) begin
        start = noisy && ($urandom_range(7) == 0);
        @(negedge clk);
        got = pair_ready;
        tick();
      end
      start = 1'b0;
      if (!got) check("pair_accept_timeout", 0, 1);
    end
    pair_valid = 1'b0;
    got = 0;
    for (int w = 0; w < 500 && !got; w++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) check("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int lens[16];
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Sixteen 34-bit words: 8 full chunks plus a 32-bit tail.
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) lens[i] = 34;
    run_line(lens, 0, 0, -1);
    check("w34_chunks", rec_chunks, 9);
    check("w34_tail_shift", rec_last_shift, 32);
    check("w34_last_flags", rec_last_flags, 1);
    check("w34_line_bits", rec_line_bits, 544);
    check("w34_done_pulses", rec_done, 1);

    // Sixteen 2-bit words: offsets step by 4, single 32-bit chunk.
    for (int i = 0; i < 16; i++) lens[i] = 2;
    run_line(lens, 0, 0, -1);
    check("w2_offset_1", rec_tl[1], 4);
    check("w2_offset_7", rec_tl[7], 28);
    check("w2_chunks", rec_chunks, 1);
    check("w2_tail_shift", rec_last_shift, 32);
    check("w2_line_bits", rec_line_bits, 32);

    // Pairs (30,34) against five-cycle downstream stalls.
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) lens[i] = (i % 2 == 0) ? 30 : 34;
    run_line(lens, 0, 0, -1);
    check("stall_chunks", rec_chunks, 8);
    check("stall_line_bits", rec_line_bits, 512);
    rdy_mode = 0;

    // Sixteen 32-bit words: exact chunk multiple, no short chunk.
    for (int i = 0; i < 16; i++) lens[i] = 32;
    run_line(lens, 0, 0, -1);
    check("w32_chunks", rec_chunks, 8);
    check("w32_short_chunks", rec_short_chunks, 0);
    check("w32_last_shift", rec_last_shift, 64);
    check("w32_last_flags", rec_last_flags, 1);

    // Over-long len1 on pair 3 counts as 34: 15*10 + 34 = 184 bits.
    for (int i = 0; i < 16; i++) lens[i] = 10;
    lens[6] = 40;
    run_line(lens, 0, 0, -1);
    check("err_flag", rec_err, 1);
    check("err_line_bits", rec_line_bits, 184);
    check("err_tail_shift", rec_last_shift, 56);

    // Reset after pair 4, then a clean line of 20-bit words.
    run_line(lens, 0, 0, 4);
    tick();
    check("post_reset_line_bits", int'(line_bits), 0);
    check("post_reset_len_err", int'(len_err), 0);
    repeat (2) tick();
    for (int i = 0; i < 16; i++) lens[i] = 20;
    run_line(lens, 0, 0, -1);
    check("clean_line_bits", rec_line_bits, 320);
    check("clean_chunks", rec_chunks, 5);
    check("clean_err", rec_err, 0);

    // Randomized lines.
    for (int n = 0; n < 30; n++) begin
      rdy_mode = $urandom_range(2);
      for (int i = 0; i < 16; i++) begin
        lens[i] = ($urandom_range(9) == 0) ? $urandom_range(35, 63)
                                           : $urandom_range(1, 34);
      end
      run_line(lens, $urandom_range(40), 1'($urandom_range(1)), -1);
      check("rand_done_pulses", rec_done, 1);
      repeat ($urandom_range(3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
